// File: rtl/lstm_dout_engine.sv
// lstm_dout_engine
//
// Back-propagates LSTM gate deltas to the input side. A job starts with
// i_start and loads 4*N_CELL dgate words (cell-major, gate inner). The engine
// then streams weight reads, one per cycle, in the order j (output row) outer,
// k (cell) middle and g (gate) inner. For every j it produces
//   o_dout[j] = sat( sum_{k,g} (w[g][j*N_CELL+k] * dgate[k*4+g]) >>> FRAC ).
// The weight memory returns i_w_data one cycle after the read strobe.
//
// Optional feature: define LSTM_DOUT_COST_EN to build the cost accumulator.
// It sums every accepted dgate and presents (sum >>> COST_SHIFT), saturated,
// on o_cost from o_done until the next accepted i_start. Without the macro
// o_cost is tied to 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_start             start pulse (honoured only when idle)
//   i_valid, i_dgate    dgate word stream, accepted when o_ready is high
//   o_ready             high while loading dgates
//   o_w_rd              weight read strobe
//   o_w_sel             gate select 0=a, 1=i, 2=f, 3=o
//   o_w_addr            weight row address j*N_CELL+k
//   i_w_data            weight data, one cycle after o_w_rd
//   o_dout, o_dout_addr delta-out word and its index j (held between strobes)
//   o_dout_valid        one-cycle strobe for o_dout
//   o_busy              engine not idle
//   o_done              completion pulse, coincident with the last o_dout_valid
//   o_cost              cost result (0 unless LSTM_DOUT_COST_EN)
module lstm_dout_engine #(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 24,
  parameter int N_CELL     = 8,
  parameter int N_OUT      = 53,
  parameter int ADDR       = 12,
  parameter int COST_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_dgate,
  output logic             o_ready,
  output logic             o_w_rd,
  output logic [1:0]       o_w_sel,
  output logic [ADDR-1:0]  o_w_addr,
  input  logic [WIDTH-1:0] i_w_data,
  output logic [WIDTH-1:0] o_dout,
  output logic [ADDR-1:0]  o_dout_addr,
  output logic             o_dout_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_cost
);

  localparam int N_WORD = 4 * N_CELL;
  localparam int IDX_W  = $clog2(N_WORD);
  localparam int ACC_W  = WIDTH + 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORD - 1);
  localparam logic [ADDR-1:0]  J_LAST   = ADDR'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    TAIL = 2'd3
  } state_t;

  // Clamp an accumulator-width value into the signed WIDTH-bit range.
  function automatic logic [WIDTH-1:0] sat_word(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    lo = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    if (v > hi) begin
      sat_word = hi[WIDTH-1:0];
    end else if (v < lo) begin
      sat_word = lo[WIDTH-1:0];
    end else begin
      sat_word = v[WIDTH-1:0];
    end
  endfunction

  state_t                   state_r;
  state_t                   state_s;
  logic                     ready_r;
  logic                     busy_r;
  logic                     rd_r;
  logic [IDX_W-1:0]         ld_cnt_r;
  logic signed [WIDTH-1:0]  dbuf_r [N_WORD];

  // Issue counters: idx = k*4+g walks the dgate buffer; addr tracks j*N_CELL+k
  // incrementally (it steps whenever g wraps, which also covers the j step).
  logic [IDX_W-1:0]         idx_r;
  logic [ADDR-1:0]          addr_r;
  logic [ADDR-1:0]          j_r;

  // One-cycle-delayed copy of the issue, aligned with the returning i_w_data.
  logic                     p1_valid_r;
  logic [IDX_W-1:0]         p1_idx_r;
  logic                     p1_first_r;
  logic                     p1_last_r;
  logic                     p1_final_r;
  logic [ADDR-1:0]          p1_j_r;

  logic signed [ACC_W-1:0]  acc_r;
  logic [WIDTH-1:0]         dout_r;
  logic [ADDR-1:0]          dout_addr_r;
  logic                     dout_valid_r;
  logic                     done_r;

  logic                     accept_s;
  logic                     start_s;
  logic                     last_issue_s;
  logic signed [2*WIDTH-1:0] wide_w_s;
  logic signed [2*WIDTH-1:0] wide_d_s;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [ACC_W-1:0]  term_s;
  logic signed [ACC_W-1:0]  acc_next_s;

  assign accept_s     = i_valid & ready_r;
  assign start_s      = i_start & (state_r == IDLE);
  assign last_issue_s = (state_r == MAC) && (j_r == J_LAST) && (idx_r == IDX_LAST);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start) state_s = LOAD;
        else         state_s = IDLE;
      end
      LOAD: begin
        if (accept_s && (ld_cnt_r == IDX_LAST)) state_s = MAC;
        else                                     state_s = LOAD;
      end
      MAC: begin
        if (last_issue_s) state_s = TAIL;
        else              state_s = MAC;
      end
      TAIL: begin
        // Leave once the final word and o_done have been presented.
        if (done_r) state_s = IDLE;
        else        state_s = TAIL;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and state-decoded output flags (registered from next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      rd_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == LOAD);
      busy_r  <= (state_s != IDLE);
      rd_r    <= (state_s == MAC);
    end
  end

  // dgate load counter and buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_r <= {IDX_W{1'b0}};
      for (int i = 0; i < N_WORD; i++) begin
        dbuf_r[i] <= {WIDTH{1'b0}};
      end
    end else if (start_s) begin
      ld_cnt_r <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      dbuf_r[ld_cnt_r] <= i_dgate;
      ld_cnt_r         <= ld_cnt_r + IDX_W'(1);
    end
  end

  // Weight read issue counters, one step per MAC cycle.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      idx_r  <= {IDX_W{1'b0}};
      addr_r <= {ADDR{1'b0}};
      j_r    <= {ADDR{1'b0}};
    end else if (state_r == MAC) begin
      if (idx_r == IDX_LAST) begin
        idx_r <= {IDX_W{1'b0}};
        j_r   <= (j_r == J_LAST) ? {ADDR{1'b0}} : j_r + ADDR'(1);
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
      if (idx_r[1:0] == 2'd3) begin
        addr_r <= addr_r + ADDR'(1);
      end
    end
  end

  // Delay the issued term tags by the weight-memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid_r <= 1'b0;
      p1_idx_r   <= {IDX_W{1'b0}};
      p1_first_r <= 1'b0;
      p1_last_r  <= 1'b0;
      p1_final_r <= 1'b0;
      p1_j_r     <= {ADDR{1'b0}};
    end else begin
      p1_valid_r <= (state_r == MAC);
      p1_idx_r   <= idx_r;
      p1_first_r <= (idx_r == {IDX_W{1'b0}});
      p1_last_r  <= (idx_r == IDX_LAST);
      p1_final_r <= last_issue_s;
      p1_j_r     <= j_r;
    end
  end

  // Product of the returning weight and its dgate, scaled back by FRAC; the
  // first term of a row replaces the accumulator instead of adding to it.
  always_comb begin
    wide_w_s = {{WIDTH{i_w_data[WIDTH-1]}}, i_w_data};
    wide_d_s = {{WIDTH{dbuf_r[p1_idx_r][WIDTH-1]}}, dbuf_r[p1_idx_r]};
    prod_s   = wide_w_s * wide_d_s;
    term_s   = ACC_W'(prod_s >>> FRAC);
    if (p1_first_r) begin
      acc_next_s = term_s;
    end else begin
      acc_next_s = acc_r + term_s;
    end
  end

  // Accumulator, delta-out register and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r        <= {ACC_W{1'b0}};
      dout_r       <= {WIDTH{1'b0}};
      dout_addr_r  <= {ADDR{1'b0}};
      dout_valid_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      if (p1_valid_r) begin
        acc_r <= acc_next_s;
      end
      if (p1_valid_r && p1_last_r) begin
        dout_r       <= sat_word(acc_next_s);
        dout_addr_r  <= p1_j_r;
        dout_valid_r <= 1'b1;
      end else begin
        dout_valid_r <= 1'b0;
      end
      done_r <= p1_valid_r & p1_final_r;
    end
  end

`ifdef LSTM_DOUT_COST_EN
  logic signed [ACC_W-1:0] cost_acc_r;
  logic [WIDTH-1:0]        cost_r;

  // Cost: running sum of accepted dgates, published when the job completes.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      cost_acc_r <= {ACC_W{1'b0}};
      cost_r     <= {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        cost_acc_r <= cost_acc_r + {{(ACC_W-WIDTH){i_dgate[WIDTH-1]}}, i_dgate};
      end
      if (p1_valid_r && p1_final_r) begin
        cost_r <= sat_word(cost_acc_r >>> COST_SHIFT);
      end
    end
  end

  assign o_cost = cost_r;
`else
  assign o_cost = {WIDTH{1'b0}};
`endif

  assign o_ready      = ready_r;
  assign o_busy       = busy_r;
  assign o_w_rd       = rd_r;
  assign o_w_sel      = idx_r[1:0];
  assign o_w_addr     = addr_r;
  assign o_dout       = dout_r;
  assign o_dout_addr  = dout_addr_r;
  assign o_dout_valid = dout_valid_r;
  assign o_done       = done_r;

endmodule

// File: tb/tb_lstm_dout_engine.sv
// Scoreboard bench for lstm_dout_engine (N_CELL=2, N_OUT=3).
// Stimulus pushes hand-computed delta-out words into a queue; a monitor pops
// and compares on every o_dout_valid, and also checks the weight-read address
// sequence, the issue-to-done latency and stray o_done pulses. A small weight
// memory model answers reads one cycle later.
module tb_lstm_dout_engine;

  localparam int WIDTH      = 32;
  localparam int FRAC       = 24;
  localparam int N_CELL     = 2;
  localparam int N_OUT      = 3;
  localparam int ADDR       = 12;
  localparam int COST_SHIFT = 3;
  localparam int N_WORD     = 4 * N_CELL;

  logic             clk;
  logic             rst;
  logic             i_start;
  logic             i_valid;
  logic [WIDTH-1:0] i_dgate;
  logic             o_ready;
  logic             o_w_rd;
  logic [1:0]       o_w_sel;
  logic [ADDR-1:0]  o_w_addr;
  logic [WIDTH-1:0] i_w_data;
  logic [WIDTH-1:0] o_dout;
  logic [ADDR-1:0]  o_dout_addr;
  logic             o_dout_valid;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_cost;

  lstm_dout_engine #(
    .WIDTH(WIDTH), .FRAC(FRAC), .N_CELL(N_CELL), .N_OUT(N_OUT),
    .ADDR(ADDR), .COST_SHIFT(COST_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid),
    .i_dgate(i_dgate), .o_ready(o_ready), .o_w_rd(o_w_rd),
    .o_w_sel(o_w_sel), .o_w_addr(o_w_addr), .i_w_data(i_w_data),
    .o_dout(o_dout), .o_dout_addr(o_dout_addr), .o_dout_valid(o_dout_valid),
    .o_busy(o_busy), .o_done(o_done), .o_cost(o_cost)
  );

  typedef struct {
    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] data;
    logic             done;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               done_cnt = 0;
  int               cyc = 0;
  int               iss_n = 0;
  int               first_rd_cyc = 0;
  bit               prev_rd = 1'b0;
  logic [WIDTH-1:0] dg [N_WORD];
  int               wmode = 0;
  logic [WIDTH-1:0] wconst = 32'h0;
  logic             pend_rd = 1'b0;
  logic [1:0]       pend_sel = 2'd0;
  logic [ADDR-1:0]  pend_addr = 12'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Weight model: mode 0 constant, mode 1 w(a, addr) = addr+1, other gates 0.
  function automatic logic [WIDTH-1:0] wfun(input logic [1:0] sel, input logic [ADDR-1:0] a);
    logic [WIDTH-1:0] v;
    if (wmode == 0) begin
      v = wconst;
    end else if (sel == 2'd0) begin
      v = WIDTH'(int'(a) + 1) << FRAC;
    end else begin
      v = 32'h0;
    end
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] cost_exp(input logic [WIDTH-1:0] v);
`ifdef LSTM_DOUT_COST_EN
    return v;
`else
    return v & 32'h0;
`endif
  endfunction

  // Monitor, scoreboard and weight memory, all sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      i_w_data  = pend_rd ? wfun(pend_sel, pend_addr) : 32'h0;
      pend_rd   = o_w_rd;
      pend_sel  = o_w_sel;
      pend_addr = o_w_addr;
      if (o_ready) iss_n = 0;
      if (o_w_rd) begin
        chk("w_sel", 64'(o_w_sel), 64'(iss_n % 4));
        chk("w_addr", 64'(o_w_addr),
            64'((iss_n / (4 * N_CELL)) * N_CELL + (iss_n / 4) % N_CELL));
        if (!prev_rd) first_rd_cyc = cyc;
        iss_n++;
      end
      prev_rd = o_w_rd;
      if (o_dout_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dout: got addr %0d data %0h expected no strobe", o_dout_addr, o_dout);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dout", 64'(o_dout), 64'(e.data));
          chk("dout_addr", 64'(o_dout_addr), 64'(e.addr));
          chk("done_with_dout", 64'(o_done), 64'(e.done));
        end
      end else if (o_done) begin
        checks++;
        errors++;
        $display("FAIL stray_done: got o_done=1 without o_dout_valid expected 0");
      end
      if (o_done) begin
        done_cnt++;
        chk("mac_to_done_cycles", 64'(cyc - first_rd_cyc + 1), 64'd26);
      end
    end
  end

  task automatic push3(input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                       input logic [WIDTH-1:0] e2);
    exp_q.push_back('{addr: 12'd0, data: e0, done: 1'b0});
    exp_q.push_back('{addr: 12'd1, data: e1, done: 1'b0});
    exp_q.push_back('{addr: 12'd2, data: e2, done: 1'b1});
  endtask

  task automatic set_dg(input logic [WIDTH-1:0] v, input bit ramp);
    for (int n = 0; n < N_WORD; n++) begin
      dg[n] = ramp ? (WIDTH'(n + 1) << FRAC) : v;
    end
  endtask

  task automatic start_and_load(input bit gaps);
    int guard;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int n = 0; n < N_WORD; n++) begin
      if (gaps) begin
        i_valid = 1'b0;
        @(negedge clk);
      end
      i_valid = 1'b1;
      i_dgate = dg[n];
      guard = 0;
      while (!o_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) chk("ready_timeout", 64'(o_ready), 64'd1);
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  task automatic run_job(input bit gaps, input bit mid_start, input logic [WIDTH-1:0] exp_cost);
    int d0;
    int guard;
    d0 = done_cnt;
    start_and_load(gaps);
    if (mid_start) begin
      repeat (3) @(negedge clk);
      chk("in_mac_before_restart", 64'(o_w_rd), 64'd1);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end
    guard = 0;
    while (done_cnt == d0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
    chk("cost", 64'(o_cost), 64'(exp_cost));
    repeat (10) @(negedge clk);
    chk("single_done", 64'(done_cnt - d0), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("idle_after_job", 64'(o_busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_ready"}, 64'(o_ready), 64'd0);
    chk({tag, "_w_rd"}, 64'(o_w_rd), 64'd0);
    chk({tag, "_w_sel"}, 64'(o_w_sel), 64'd0);
    chk({tag, "_w_addr"}, 64'(o_w_addr), 64'd0);
    chk({tag, "_dout"}, 64'(o_dout), 64'd0);
    chk({tag, "_dout_addr"}, 64'(o_dout_addr), 64'd0);
    chk({tag, "_dout_valid"}, 64'(o_dout_valid), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_cost"}, 64'(o_cost), 64'd0);
  endtask

  initial begin
    int d0;
    int nrd;
    int guard;
    rst = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_dgate = 32'h0;
    i_w_data = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1.0 * 0.5 over 8 terms = 4.0 per row.
    set_dg(32'h0100_0000, 1'b0);
    wmode = 0;
    wconst = 32'h0080_0000;
    push3(32'h0400_0000, 32'h0400_0000, 32'h0400_0000);
    run_job(1'b0, 1'b0, cost_exp(32'h0100_0000));

    // 100.0 * 100.0 saturates high, 100.0 * -100.0 saturates low.
    set_dg(32'h6400_0000, 1'b0);
    wconst = 32'h6400_0000;
    push3(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_job(1'b0, 1'b0, cost_exp(32'h6400_0000));
    wconst = 32'h9C00_0000;
    push3(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_job(1'b0, 1'b0, cost_exp(32'h6400_0000));

    // i_valid gaps during load and an ignored i_start during MAC.
    set_dg(32'h0100_0000, 1'b0);
    wconst = 32'h0080_0000;
    push3(32'h0400_0000, 32'h0400_0000, 32'h0400_0000);
    run_job(1'b1, 1'b1, cost_exp(32'h0100_0000));

    // dgates 1..8, weights addr+1 on gate a only: rows 11, 23, 35; cost 36/8.
    set_dg(32'h0, 1'b1);
    wmode = 1;
    push3(32'h0B00_0000, 32'h1700_0000, 32'h2300_0000);
    run_job(1'b0, 1'b0, cost_exp(32'h0480_0000));

    // Reset on the 5th MAC cycle aborts the job silently.
    set_dg(32'h0100_0000, 1'b0);
    wmode = 0;
    wconst = 32'h0080_0000;
    d0 = done_cnt;
    start_and_load(1'b0);
    nrd = 0;
    guard = 0;
    while (nrd < 5 && guard < 100) begin
      if (o_w_rd) nrd++;
      if (nrd < 5) @(negedge clk);
      guard++;
    end
    chk("reached_mac_cycle5", 64'(nrd), 64'd5);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_mac_reset");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    push3(32'h0400_0000, 32'h0400_0000, 32'h0400_0000);
    run_job(1'b0, 1'b0, cost_exp(32'h0100_0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
